// File: rtl/mac_sequencer.sv
// mac_sequencer: drives a shared 16-bit MAC through one TAPS-long dot product
// plus bias per kernel window, then holds the sum on a valid/ready output.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start, bias           begin a window; bias is sampled on the accepting edge
//   busy                  high while a window is in flight or its result is held
//   rd_en, rd_addr        tap-buffer read strobe/address (data returns next cycle)
//   in_data, w_data       tap-buffer read data
//   mac_in, mac_w, mac_b  MAC operands (in_data, w_data, running accumulator)
//   mac_out               MAC result
//   out_data, out_valid   finished sum and its valid flag
//   out_ready             downstream accept
module mac_sequencer #(
  parameter int DW   = 16,
  parameter int TAPS = 9,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] bias,
  output logic          busy,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] in_data,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] mac_in,
  output logic [DW-1:0] mac_w,
  output logic [DW-1:0] mac_b,
  input  logic [DW-1:0] mac_out,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, TAIL, HOLD} state_t;

  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  state_t        state;
  logic [AW-1:0] cnt;
  logic [DW-1:0] acc;
  logic          data_v;
  logic          busy_q;
  logic          rd_en_q;
  logic          out_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      data_v      <= 1'b0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // Read data lags the strobe by one cycle; data_v marks the cycle it lands.
      data_v <= rd_en_q;
      if (data_v) acc <= mac_out;

      // Loading bias never collides with accumulation: data_v is low in IDLE/HOLD.
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= bias;
            cnt     <= '0;
            state   <= RUN;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            state   <= TAIL;
            rd_en_q <= 1'b0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        TAIL: begin
          state       <= HOLD;
          out_valid_q <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (start) begin
              acc     <= bias;
              cnt     <= '0;
              state   <= RUN;
              rd_en_q <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = cnt;
  assign mac_in    = in_data;
  assign mac_w     = w_data;
  assign mac_b     = acc;
  assign out_data  = acc;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomised and directed bench for mac_sequencer with a scoreboard. The bench
// models the tap buffers (synchronous read) and the external MAC unit.
module tb_mac_sequencer;

  localparam int DW   = 16;
  localparam int TAPS = 9;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] bias = '0;
  logic          busy;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] w_data = '0;
  logic [DW-1:0] mac_in, mac_w, mac_b;
  logic [DW-1:0] mac_out;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] in_mem [2**AW];
  logic [DW-1:0] w_mem  [2**AW];
  logic [DW-1:0] exp_q [$];

  mac_sequencer #(.DW(DW), .TAPS(TAPS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .in_data(in_data), .w_data(w_data),
    .mac_in(mac_in), .mac_w(mac_w), .mac_b(mac_b), .mac_out(mac_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      in_data <= in_mem[rd_addr];
      w_data  <= w_mem[rd_addr];
    end
  end

  assign mac_out = mac_w * mac_in + mac_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: bias plus the sum of full products, reduced mod 2^DW at the end.
  function automatic logic [DW-1:0] ref_sum(input logic [DW-1:0] b);
    logic [63:0] s;
    s = 64'(b);
    for (int i = 0; i < TAPS; i++) s = s + 64'(in_mem[i]) * 64'(w_mem[i]);
    return s[DW-1:0];
  endfunction

  task automatic fill_const(input logic [DW-1:0] a, input logic [DW-1:0] w);
    for (int i = 0; i < 2**AW; i++) begin
      in_mem[i] = a;
      w_mem[i]  = w;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 2**AW; i++) begin
      in_mem[i] = DW'($urandom);
      w_mem[i]  = DW'($urandom);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_result", 32'(out_data), 32'hFFFF_FFFF);
      else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic pulse_start(input logic [DW-1:0] b);
    @(posedge clk); #1;
    bias  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bias  = DW'($urandom);
  endtask

  // Entered just after E0; returns at the negedge where out_valid is first seen.
  task automatic wait_valid(input bit strict);
    int n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (strict && n < TAPS) begin
        chk("rd_en_run", 32'(rd_en), 1);
        chk("rd_addr", 32'(rd_addr), 32'(n));
      end
      if (strict && n == TAPS) chk("rd_en_tail", 32'(rd_en), 0);
      if (n >= 40) begin
        chk("valid_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      n++;
    end
    if (strict) chk("latency", 32'(n), 32'(TAPS + 1));
  endtask

  task automatic handshake(input bit strict);
    logic [DW-1:0] held;
    int w = 0;
    held = out_data;
    while (!out_ready) begin
      @(posedge clk); #1;
      w++;
      out_ready = (w >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data", 32'(out_data), 32'(held));
    end
    @(posedge clk); #1;
    if (strict) begin
      @(negedge clk);
      chk("valid_pulse", 32'(out_valid), 0);
    end
  endtask

  task automatic do_window(input logic [DW-1:0] b, input bit strict);
    exp_q.push_back(ref_sum(b));
    pulse_start(b);
    wait_valid(strict);
    handshake(strict);
  endtask

  initial begin
    logic [DW-1:0] held, b;
    fill_const(0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_mac_b", 32'(mac_b), 0);
    rst = 1'b0;

    // Unit weights and inputs, then truncating products, then a wrapping sum.
    out_ready = 1'b1;
    fill_const(16'h0001, 16'h0001);
    do_window(16'h0000, 1'b1);
    fill_const(16'h0100, 16'h0100);
    do_window(16'h1234, 1'b1);
    fill_const(16'h2000, 16'h0002);
    do_window(16'h0000, 1'b1);

    // Backpressure with a start pulse that must be ignored.
    out_ready = 1'b0;
    fill_rand();
    b = DW'($urandom);
    exp_q.push_back(ref_sum(b));
    pulse_start(b);
    wait_valid(1'b1);
    held = out_data;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start = (k == 2);
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'(held));
      chk("bp_rd_en", 32'(rd_en), 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_busy", 32'(busy), 0);
    chk("bp_idle_valid", 32'(out_valid), 0);
    chk("bp_idle_rd_en", 32'(rd_en), 0);

    // Back-to-back: second window accepted in HOLD with no IDLE bubble.
    out_ready = 1'b0;
    fill_rand();
    b = DW'($urandom);
    exp_q.push_back(ref_sum(b));
    pulse_start(b);
    wait_valid(1'b0);
    fill_const(16'h0002, 16'h0003);
    exp_q.push_back(ref_sum(16'h0001));
    @(posedge clk); #1;
    out_ready = 1'b1;
    start = 1'b1;
    bias  = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
    bias  = DW'($urandom);
    wait_valid(1'b1);
    handshake(1'b1);

    // Asynchronous reset in the middle of RUN.
    fill_const(16'h0001, 16'h0001);
    pulse_start(16'h0005);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_addr", 32'(rd_addr), 4);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd_en", 32'(rd_en), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_mac_b", 32'(mac_b), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_window(16'h0000, 1'b1);

    // Random windows with random backpressure.
    for (int i = 0; i < 20; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      fill_rand();
      do_window(DW'($urandom), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
